// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the 7-segment scan driver:
// hex segment patterns (active-high, bit0=a .. bit6=g) and the sizing
// arithmetic for the slot prescaler.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Clock cycles per digit slot.
  function automatic int calc_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // Prescaler width for a given slot length; never narrower than one bit.
  function automatic int calc_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex-to-7-segment decoder, active-high g..a pattern.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] pattern
);

  // Look up the segment pattern for the nibble.
  always_comb begin
    pattern = SEG_BLANK;
    case (nibble)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = SEG_A;
      4'hB: pattern = SEG_B;
      4'hC: pattern = SEG_C;
      4'hD: pattern = SEG_D;
      4'hE: pattern = SEG_E;
      4'hF: pattern = SEG_F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// A prescaler divides each digit slot; the first BLANK_CYCLES of every
// slot keep all anodes off so the segment lines settle before the next
// digit lights. New values are staged in a pending buffer and only reach
// the display buffer at the frame boundary, so a frame never mixes old
// and new digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int CLK_HZ         = 50_000_000,
  parameter int SCAN_HZ        = 1000,
  parameter int NUM_DIGITS     = 4,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                          clock_50mhz,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       valor,
  input  logic [NUM_DIGITS-1:0]         puntos,
  input  logic [NUM_DIGITS-1:0]         habilitar,
  input  logic                          cargar,
  input  logic                          sin_ceros,
  output logic [6:0]                    segmentos,
  output logic                          punto,
  output logic [NUM_DIGITS-1:0]         anodos,
  output logic [$clog2(NUM_DIGITS)-1:0] digito_activo,
  output logic                          fin_cuadro
);

  localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
  localparam int PW  = calc_width(DIV);
  localparam int IW  = $clog2(NUM_DIGITS);

  localparam logic [PW-1:0]         PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]         BLANK_END  = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};

  // Refuse to build configurations that cannot work.
  generate
    if (DIV < BLANK_CYCLES + 2) begin : g_bad_div
      $error("seg7_scan_driver: slot length CLK_HZ/SCAN_HZ must be at least BLANK_CYCLES+2");
    end
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seg7_scan_driver: NUM_DIGITS must be in 2..8");
    end
  endgenerate

  // Scan position
  logic [PW-1:0] presc_reg;
  logic [IW-1:0] idx_reg;
  logic          slot_end;
  logic          frame_wrap;

  // Pending and display buffers
  logic [4*NUM_DIGITS-1:0] pend_val_reg;
  logic [NUM_DIGITS-1:0]   pend_dp_reg;
  logic [NUM_DIGITS-1:0]   pend_en_reg;
  logic                    pend_valid_reg;
  logic [4*NUM_DIGITS-1:0] disp_val_reg;
  logic [NUM_DIGITS-1:0]   disp_dp_reg;
  logic [NUM_DIGITS-1:0]   disp_en_reg;

  // Per-digit derived signals
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] upper_zero;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic [NUM_DIGITS-1:0] an_sel;

  // Next values of the registered outputs (active-high)
  logic [3:0]            cur_nib;
  logic [6:0]            dec_pattern;
  logic [6:0]            seg_next;
  logic                  dp_next;
  logic [NUM_DIGITS-1:0] an_next;

  // Output registers (already at pin polarity)
  logic [6:0]            seg_reg;
  logic                  dp_reg;
  logic [NUM_DIGITS-1:0] an_reg;
  logic [IW-1:0]         dig_reg;
  logic                  fin_reg;

  assign slot_end   = (presc_reg == PRESC_LAST);
  assign frame_wrap = slot_end && (idx_reg == IDX_LAST);

  // Advance the slot prescaler and the digit index.
  always_ff @(posedge clock_50mhz or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else if (slot_end) begin
      presc_reg <= '0;
      idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Stage loads in the pending buffer and commit them at the frame wrap;
  // a load landing exactly on the wrap bypasses straight to the display.
  always_ff @(posedge clock_50mhz or posedge reset) begin
    if (reset) begin
      pend_val_reg   <= '0;
      pend_dp_reg    <= '0;
      pend_en_reg    <= '0;
      pend_valid_reg <= 1'b0;
      disp_val_reg   <= '0;
      disp_dp_reg    <= '0;
      disp_en_reg    <= '0;
    end else if (cargar && frame_wrap) begin
      disp_val_reg   <= valor;
      disp_dp_reg    <= puntos;
      disp_en_reg    <= habilitar;
      pend_valid_reg <= 1'b0;
    end else if (cargar) begin
      pend_val_reg   <= valor;
      pend_dp_reg    <= puntos;
      pend_en_reg    <= habilitar;
      pend_valid_reg <= 1'b1;
    end else if (frame_wrap && pend_valid_reg) begin
      disp_val_reg   <= pend_val_reg;
      disp_dp_reg    <= pend_dp_reg;
      disp_en_reg    <= pend_en_reg;
      pend_valid_reg <= 1'b0;
    end
  end

  // Split the display word into nibbles and build the one-hot anode select.
  // upper_zero[i] means digit i and every digit above it hold zero; digit 0
  // is never zero-blanked so it has no entry in that chain.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign nib[gi]    = disp_val_reg[4*gi +: 4];
      assign an_sel[gi] = (idx_reg == IW'(gi));
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        if (gi == NUM_DIGITS - 1) begin : g_top
          assign upper_zero[gi] = (disp_val_reg[4*gi +: 4] == 4'h0);
        end else begin : g_mid
          assign upper_zero[gi] = (disp_val_reg[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
        end
        assign lz_blank[gi] = sin_ceros && upper_zero[gi];
      end
    end
  endgenerate

  assign upper_zero[0] = 1'b0;
  assign cur_nib       = nib[idx_reg];

  seg7_decoder u_decoder (
    .nibble  (cur_nib),
    .pattern (dec_pattern)
  );

  // Choose what the current slot shows. Segments follow the digit even in
  // the blanking window so they have settled when the anode turns on.
  always_comb begin
    seg_next = SEG_BLANK;
    dp_next  = 1'b0;
    an_next  = '0;
    if (disp_en_reg[idx_reg]) begin
      if (!lz_blank[idx_reg]) begin
        seg_next = dec_pattern;
      end
      dp_next = disp_dp_reg[idx_reg];
      if (presc_reg >= BLANK_END) begin
        an_next = an_sel;
      end
    end
  end

  // Register the pin drive at board polarity, plus the scan status.
  always_ff @(posedge clock_50mhz or posedge reset) begin
    if (reset) begin
      seg_reg <= SEG_OFF;
      dp_reg  <= SEG_ACTIVE_LOW;
      an_reg  <= AN_OFF;
      dig_reg <= '0;
      fin_reg <= 1'b0;
    end else begin
      seg_reg <= seg_next ^ SEG_OFF;
      dp_reg  <= dp_next ^ SEG_ACTIVE_LOW;
      an_reg  <= an_next ^ AN_OFF;
      dig_reg <= idx_reg;
      fin_reg <= (idx_reg == '0) && (dig_reg == IDX_LAST);
    end
  end

  assign segmentos     = seg_reg;
  assign punto         = dp_reg;
  assign anodos        = an_reg;
  assign digito_activo = dig_reg;
  assign fin_cuadro    = fin_reg;

endmodule
